sync_event_arbiter: RTL



---
 rtl/sync_event_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sync_event_arbiter.sv
// Synchronizes N asynchronous event lines, latches their rising edges as pending
// events, and offers them round-robin to one consumer over valid/ready.
module sync_event_arbiter #(
    parameter int   N         = 4,
    parameter int   ID_W      = 2,
    parameter int   FLOPS     = 2,
    parameter logic RESET_LVL = 1'b0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req_async,
    input  logic [N-1:0]    chan_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    ovf,
    input  logic [N-1:0]    ovf_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    logic [FLOPS-1:0] sync_q [N];
    logic [N-1:0]     sync_w;
    logic [N-1:0]     hist_q;
    logic [N-1:0]     rise;
    logic [N-1:0]     offered;
    logic [N-1:0]     acc;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     ovf_q, ovf_d;

    state_t           state_q;
    logic             evt_valid_q;
    logic [ID_W-1:0]  evt_id_q;
    logic [ID_W-1:0]  last_grant_q;

    logic [N-1:0]     cand;
    logic [N-1:0]     cand_sh;
    logic             sel_found;
    logic [ID_W-1:0]  sel_id;
    int               idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sync_q[gi] <= {FLOPS{RESET_LVL}};
                end else begin
                    sync_q[gi] <= {sync_q[gi][FLOPS-2:0], req_async[gi]};
                end
            end

            assign sync_w[gi]  = sync_q[gi][FLOPS-1];
            assign rise[gi]    = sync_w[gi] & ~hist_q[gi] & chan_en[gi];
            assign offered[gi] = evt_valid_q && (evt_id_q == ID_W'(gi));
            assign acc[gi]     = offered[gi] & evt_ready;

            // A new edge always re-arms; disabling only drops events not currently on offer.
            assign pending_d[gi] = rise[gi]                        ? 1'b1 :
                                   acc[gi]                         ? 1'b0 :
                                   (!chan_en[gi] && !offered[gi])  ? 1'b0 :
                                                                     pending_q[gi];
            assign ovf_d[gi] = (rise[gi] & pending_q[gi] & ~acc[gi]) |
                               (ovf_q[gi] & ~ovf_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hist_q    <= {N{RESET_LVL}};
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            hist_q    <= sync_w;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cand = pending_q & chan_en;

    // First candidate after the last granted channel, wrapping modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        cand_sh   = '0;
        for (int k = 1; k <= N; k++) begin
            idx     = (int'(last_grant_q) + k) % N;
            cand_sh = cand >> idx;
            if (!sel_found && cand_sh[0]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        evt_id_q    <= sel_id;
                        evt_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        evt_valid_q  <= 1'b0;
                        last_grant_q <= evt_id_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    evt_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule
